// File: rtl/m_matkey_scan_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package matkey_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic {DRIVE = 1'b0, EVAL = 1'b1} state_t;

    typedef struct packed {
        logic       any;
        logic       multi;
        logic [3:0] idx;
    } key_sel_t;

    // Lowest set index plus "any" and "more than one" population flags.
    function automatic key_sel_t lowest_key(input logic [NUM_KEYS-1:0] v);
        key_sel_t s;
        s.any   = |v;
        s.multi = |(v & (v - NUM_KEYS'(1)));
        s.idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) s.idx = 4'(i);
        end
        return s;
    endfunction
endpackage

// File: rtl/m_matkey_scan_if.sv
// Keypad pins plus the key/pushed/key_valid outputs toward the display decoder.
interface m_matkey_scan_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key;
    logic       pushed;
    logic       key_valid;

    modport master (input row_n, output col_n, key, pushed, key_valid);
    modport slave  (output row_n, input col_n, key, pushed, key_valid);
endinterface

// File: rtl/m_matkey_scan_tick.sv
// Column slot counter: terminal count on SCAN_DIV-1, wraps, synchronous clear.
module m_scan_tick #(
    parameter int SCAN_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_reg;

    assign tc = (cnt_reg == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || tc) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end
endmodule

// File: rtl/m_matkey_scan.sv
// 4x4 keypad scanner with whole-frame debounce and registered key/pushed outputs.
// Optional MATKEY_MULTI_REJECT_EN: a stable frame with 2+ keys reads as no key.
module m_matkey_scan
    import matkey_pkg::*;
#(
    parameter int SCAN_DIV     = 500000,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic            clk,
    input  logic            rst,
    m_matkey_scan_if.master kp
);
    localparam int SW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [SW-1:0] SCNT_MAX = SW'(DEBOUNCE_CNT - 1);
`ifdef MATKEY_MULTI_REJECT_EN
    localparam logic MULTI_REJECT = 1'b1;
`else
    localparam logic MULTI_REJECT = 1'b0;
`endif

    state_t              state_reg, state_next;
    logic [1:0]          col_reg, col_next;
    logic [3:0]          col_n_reg, col_n_next;
    logic [NUM_KEYS-1:0] snap_reg;
    logic [NUM_KEYS-1:0] cand_reg, cand_next;
    logic [NUM_KEYS-1:0] stable_reg, stable_next;
    logic [SW-1:0]       scnt_reg, scnt_next;
    logic [NUM_KEYS-1:0] stable_keys;
    logic [3:0]          key_reg;
    logic                pushed_reg, key_valid_reg;
    logic                tc, tick_clr, accept;
    key_sel_t            sel;

    m_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tc  (tc)
    );

    // Snapshot is column-major (col*4+row); reorder to key index row*4+col.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            assign stable_keys[gi] = stable_next[(gi % NUM_COLS) * NUM_ROWS + gi / NUM_COLS];
        end
    endgenerate

    assign sel    = lowest_key(stable_keys);
    assign accept = sel.any & ~(MULTI_REJECT & sel.multi);

    always_comb begin
        state_next  = state_reg;
        col_next    = col_reg;
        col_n_next  = col_n_reg;
        cand_next   = cand_reg;
        scnt_next   = scnt_reg;
        stable_next = stable_reg;
        tick_clr    = 1'b0;
        case (state_reg)
            DRIVE: begin
                if (tc) begin
                    if (col_reg == 2'd3) begin
                        state_next = EVAL;
                    end else begin
                        col_next   = col_reg + 2'd1;
                        col_n_next = ~(4'b0001 << (col_reg + 2'd1));
                    end
                end
            end
            EVAL: begin
                tick_clr   = 1'b1;
                state_next = DRIVE;
                col_next   = 2'd0;
                col_n_next = 4'b1110;
                if (snap_reg != cand_reg) begin
                    cand_next = snap_reg;
                    scnt_next = '0;
                end else if (scnt_reg != SCNT_MAX) begin
                    scnt_next = scnt_reg + SW'(1);
                end
                if (scnt_next == SCNT_MAX) stable_next = cand_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= DRIVE;
            col_reg       <= 2'd0;
            col_n_reg     <= 4'b1110;
            snap_reg      <= '0;
            cand_reg      <= '0;
            scnt_reg      <= '0;
            stable_reg    <= '0;
            key_reg       <= 4'h0;
            pushed_reg    <= 1'b0;
            key_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            col_n_reg     <= col_n_next;
            cand_reg      <= cand_next;
            scnt_reg      <= scnt_next;
            stable_reg    <= stable_next;
            key_valid_reg <= 1'b0;
            if (state_reg == DRIVE && tc) begin
                snap_reg[{col_reg, 2'b00} +: NUM_ROWS] <= ~kp.row_n;
            end
            if (state_reg == EVAL) begin
                pushed_reg <= accept;
                if (accept) begin
                    key_reg       <= sel.idx;
                    key_valid_reg <= !pushed_reg || (sel.idx != key_reg);
                end
            end
        end
    end

    assign kp.col_n     = col_n_reg;
    assign kp.key       = key_reg;
    assign kp.pushed    = pushed_reg;
    assign kp.key_valid = key_valid_reg;
endmodule
